// File: rtl/change_dispenser.sv
// change_dispenser: pays out a sale's change or a cancel refund as unit coins
// through a pulsed hopper motor. Each coin is confirmed by the exit sensor.
// A missing confirmation is retried, and repeated misses park the block in JAM
// until a service clear arrives.
//
// Optional build macro: CHANGE_DISPENSER_SENSE_SYNC_EN
//   defined   -> coin_sense goes through a 2-flop synchronizer and a
//                rising-edge detector (adds 2 cycles of latency; a sensor
//                held high counts once).
//   undefined -> coin_sense is taken as a synchronous one-cycle pulse.
//
// Request handshake: a job is requested by the rising edge of
// (pdt | rtn != 0). It is accepted only in IDLE. An edge seen in any other
// state is dropped and flagged on ovr for one cycle. There is no ready
// signal, because the controller is never back-pressured.
module change_dispenser #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pdt,
  input  logic [2:0] cng,
  input  logic [2:0] rtn,
  input  logic       coin_sense,
  input  logic       jam_clr,
  output logic       hopper_drv,
  output logic       busy,
  output logic       done,
  output logic       jam,
  output logic       ovr,
  output logic [3:0] dispensed
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TIME_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_JAM   = 3'd4
  } state_t;

  state_t        state, state_d;
  logic          req_prev;
  logic [3:0]    remaining, remaining_d;
  logic [3:0]    dispensed_d;
  logic [RW-1:0] retry, retry_d;
  logic [TW-1:0] timer, timer_d;
  logic [PW-1:0] pulse_cnt, pulse_cnt_d;
  logic          hopper_drv_d, busy_d, done_d, jam_d, ovr_d;

  logic          req_lvl, req_edge;
  logic [3:0]    amount;
  logic          sense;

`ifdef CHANGE_DISPENSER_SENSE_SYNC_EN
  logic [2:0] sense_sr;

  // Synchronize the raw sensor and keep one extra stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sense_sr <= 3'b000;
    else     sense_sr <= {sense_sr[1:0], coin_sense};
  end

  assign sense = sense_sr[1] & ~sense_sr[2];
`else
  assign sense = coin_sense;
`endif

  assign req_lvl  = pdt | (rtn != 3'd0);
  assign req_edge = req_lvl & ~req_prev;
  assign amount   = (pdt ? {1'b0, cng} : 4'd0) + {1'b0, rtn};

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      req_prev   <= 1'b1;
      remaining  <= 4'd0;
      dispensed  <= 4'd0;
      retry      <= '0;
      timer      <= '0;
      pulse_cnt  <= '0;
      hopper_drv <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      jam        <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      state      <= state_d;
      req_prev   <= req_lvl;
      remaining  <= remaining_d;
      dispensed  <= dispensed_d;
      retry      <= retry_d;
      timer      <= timer_d;
      pulse_cnt  <= pulse_cnt_d;
      hopper_drv <= hopper_drv_d;
      busy       <= busy_d;
      done       <= done_d;
      jam        <= jam_d;
      ovr        <= ovr_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d      = state;
    remaining_d  = remaining;
    dispensed_d  = dispensed;
    retry_d      = retry;
    timer_d      = timer;
    pulse_cnt_d  = pulse_cnt;
    hopper_drv_d = hopper_drv;
    busy_d       = busy;
    jam_d        = jam;
    done_d       = 1'b0;
    ovr_d        = req_edge & (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (req_edge) begin
          remaining_d = amount;
          dispensed_d = 4'd0;
          retry_d     = '0;
          timer_d     = '0;
          pulse_cnt_d = '0;
          if (amount == 4'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d      = S_DRIVE;
            hopper_drv_d = 1'b1;
            busy_d       = 1'b1;
          end
        end
      end

      S_DRIVE: begin
        // Sensor is ignored while the motor is being pulsed.
        if (pulse_cnt == PULSE_LAST) begin
          state_d      = S_WAIT;
          hopper_drv_d = 1'b0;
          pulse_cnt_d  = '0;
          timer_d      = '0;
        end else begin
          pulse_cnt_d = pulse_cnt + 1'b1;
        end
      end

      S_WAIT: begin
        // A sense in the last timeout cycle still counts: sense wins.
        if (sense) begin
          remaining_d = remaining - 4'd1;
          dispensed_d = dispensed + 4'd1;
          retry_d     = '0;
          timer_d     = '0;
          if (remaining == 4'd1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d      = S_DRIVE;
            hopper_drv_d = 1'b1;
          end
        end else if (timer == TIME_LAST) begin
          timer_d = '0;
          retry_d = retry + 1'b1;
          if (retry == RETRY_LAST) begin
            state_d = S_JAM;
            jam_d   = 1'b1;
          end else begin
            state_d      = S_DRIVE;
            hopper_drv_d = 1'b1;
          end
        end else begin
          timer_d = timer + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_JAM: begin
        // Partial count stays visible on dispensed after the clear.
        if (jam_clr) begin
          state_d     = S_IDLE;
          remaining_d = 4'd0;
          jam_d       = 1'b0;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d      = S_IDLE;
        hopper_drv_d = 1'b0;
        busy_d       = 1'b0;
        jam_d        = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios followed by randomized jobs.
// Each job uses a "sensor plan" with one entry per motor attempt. The entry
// is the WAIT cycle (1..16) in which the hopper reports a coin, or 0 when
// the coin never arrives. A plain arithmetic model over that plan predicts
// the burst count, drive cycles, completion cycle, coin count and jam outcome.
module tb_change_dispenser;

  localparam int P  = 4;
  localparam int T  = 16;
  localparam int MR = 2;

  logic       clk;
  logic       rst;
  logic       pdt;
  logic [2:0] cng;
  logic [2:0] rtn;
  logic       coin_sense;
  logic       jam_clr;
  logic       hopper_drv;
  logic       busy;
  logic       done;
  logic       jam;
  logic       ovr;
  logic [3:0] dispensed;

  int total;
  int bad;
  int plan[$];

  change_dispenser #(.PULSE_CYCLES(P), .TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .pdt(pdt), .cng(cng), .rtn(rtn),
    .coin_sense(coin_sense), .jam_clr(jam_clr), .hopper_drv(hopper_drv),
    .busy(busy), .done(done), .jam(jam), .ovr(ovr), .dispensed(dispensed)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random sensor plan for a job of the given size. Stops early on a jam.
  task automatic make_plan(input int amount, input int fail_pct);
    int coins;
    int fails;
    plan.delete();
    coins = 0;
    fails = 0;
    while (coins < amount && fails < MR) begin
      if ($urandom_range(0, 99) < fail_pct) begin
        plan.push_back(0);
        fails++;
      end else begin
        plan.push_back(int'($urandom_range(1, T)));
        coins++;
        fails = 0;
      end
    end
  endtask

  // Run one job with the current plan and check it against the model.
  task automatic run_job(input string name, input logic p, input logic [2:0] c,
                         input logic [2:0] r, input int hold, input int ovr_at);
    int  amount, e_disp, e_end, e_att, fails, cyc, end_cyc;
    int  hi_cnt, bursts, ovr_cnt, att, w;
    bit  e_jam, prev_drv, in_wait;

    // Reference model over the plan
    amount = (p ? int'(c) : 0) + int'(r);
    e_disp = 0; e_end = 0; e_att = 0; fails = 0; e_jam = 0;
    for (int i = 0; i < plan.size(); i++) begin
      if (e_disp == amount || e_jam) break;
      e_att++;
      e_end += P + ((plan[i] != 0) ? plan[i] : T);
      if (plan[i] != 0) begin
        e_disp++;
        fails = 0;
      end else begin
        fails++;
        if (fails == MR) e_jam = 1;
      end
    end
    e_end += 1;

    // Drive the request; the next edge is the capture edge
    pdt = p; cng = c; rtn = r;
    tick();
    cyc = 1; end_cyc = -1; hi_cnt = 0; bursts = 0; ovr_cnt = 0;
    att = 0; w = 0; prev_drv = 0; in_wait = 0;
    while (cyc <= 1000) begin
      if (cyc == hold) begin pdt = 0; cng = 0; rtn = 0; end
      if (ovr_at > 0 && cyc == ovr_at) pdt = 1;
      if (ovr_at > 0 && cyc == ovr_at + 1) pdt = 0;
      coin_sense = 0;
      if (cyc == 1) check({name, " dispensed_cleared"}, dispensed, 0);
      hi_cnt  += int'(hopper_drv);
      ovr_cnt += int'(ovr);
      if (done || jam) begin end_cyc = cyc; break; end
      // Hopper model: count bursts, report coins in the planned WAIT cycle
      if (hopper_drv && !prev_drv) begin bursts++; att++; in_wait = 0; end
      if (!hopper_drv && prev_drv) begin in_wait = 1; w = 0; end
      if (in_wait) begin
        w++;
        if (att >= 1 && att <= plan.size() && plan[att-1] == w) begin
          coin_sense = 1;
          in_wait = 0;
        end
      end
      // Stray sensor pulses while the motor runs must be ignored
      if (hopper_drv && $urandom_range(0, 7) == 0) coin_sense = 1;
      prev_drv = hopper_drv;
      tick();
      cyc++;
    end
    pdt = 0; cng = 0; rtn = 0; coin_sense = 0;

    check({name, " end_cycle"}, end_cyc, e_end);
    check({name, " bursts"}, bursts, e_att);
    check({name, " drive_cycles"}, hi_cnt, P * e_att);
    check({name, " dispensed"}, dispensed, e_disp);
    check({name, " jam"}, jam, e_jam);
    check({name, " done"}, done, !e_jam);
    check({name, " ovr_count"}, ovr_cnt, (ovr_at > 0) ? 1 : 0);

    if (e_jam) begin
      check({name, " busy_in_jam"}, busy, 1);
      coin_sense = 1;
      tick();
      coin_sense = 0;
      check({name, " jam_held"}, jam, 1);
      check({name, " jam_no_drive"}, hopper_drv, 0);
      check({name, " jam_sense_ignored"}, dispensed, e_disp);
      jam_clr = 1;
      tick();
      jam_clr = 0;
      check({name, " jam_cleared"}, jam, 0);
      check({name, " busy_after_clr"}, busy, 0);
      check({name, " partial_kept"}, dispensed, e_disp);
      check({name, " no_done_on_jam"}, done, 0);
    end else begin
      tick();
      check({name, " done_one_cycle"}, done, 0);
      check({name, " busy_after"}, busy, 0);
      check({name, " drive_after"}, hopper_drv, 0);
    end
    tick();
    tick();
  endtask

  initial begin
    logic       rp;
    logic [2:0] rc, rr;
    int         hi_seen, busy_seen;

    total = 0; bad = 0;
    rst = 1; pdt = 0; cng = 0; rtn = 0; coin_sense = 0; jam_clr = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset hopper_drv", hopper_drv, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset jam", jam, 0);
    check("reset ovr", ovr, 0);
    check("reset dispensed", dispensed, 0);
    @(negedge clk);
    rst = 0;
    tick();
    tick();

    // Sale with change, sensor 3 cycles into each WAIT
    plan = '{3, 3};
    run_job("sale", 1'b1, 3'd2, 3'd0, 1, 0);

    // Refund held for 2 cycles: one job, no ovr
    make_plan(3, 0);
    run_job("refund_held", 1'b0, 3'd0, 3'd3, 2, 0);

    // Exact payment
    plan.delete();
    run_job("exact", 1'b1, 3'd0, 3'd0, 1, 0);

    // Jam: no sensor at all
    plan = '{0, 0};
    run_job("jam", 1'b0, 3'd0, 3'd2, 1, 0);

    // Sense on the last WAIT cycle resets retry; mid-job request flags ovr
    plan = '{0, 16, 0, 16, 16};
    run_job("boundary", 1'b1, 3'd1, 3'd2, 1, 3);

    // Randomized jobs
    for (int k = 0; k < 8; k++) begin
      rp = 1'($urandom_range(0, 1));
      rc = 3'($urandom_range(0, 7));
      rr = 3'($urandom_range(0, 7));
      if (!rp && rr == 3'd0) rr = 3'd1;
      make_plan((rp ? int'(rc) : 0) + int'(rr), 20);
      run_job($sformatf("rand%0d", k), rp, rc, rr, int'($urandom_range(1, 2)), 0);
    end

    // Reset mid-DRIVE with refund still requested
    rtn = 3'd3;
    tick();
    tick();
    check("rst pre_drive", hopper_drv, 1);
    #2;
    rst = 1;
    #1;
    check("rst hopper_drv", hopper_drv, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst jam", jam, 0);
    check("rst dispensed", dispensed, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    hi_seen = 0; busy_seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      hi_seen   += int'(hopper_drv);
      busy_seen += int'(busy | done | jam);
    end
    check("rst no_restart_drive", hi_seen, 0);
    check("rst no_restart_busy", busy_seen, 0);
    rtn = 3'd0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
